sobel_window_ctrl: RTL and testbench

Frame sequencer that sits in front of the Sobel gradient/magnitude stage. It accepts a raster-order 8-bit pixel stream with a valid/ready handshake and keeps two line buffers plus a 3x3 shift window. For every interior pixel it issues one window with a one-cycle valid strobe, which drives the Sobel stage's valid_in and p0..p8 inputs. It also reports the window-centre coordinates and frame completion, so the downstream NMS and hysteresis stages can track position.

---
 rtl/sobel_pkg.sv | 26 ++
 rtl/sobel_line_buf.sv | 26 ++
 rtl/sobel_window_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window sequencer.
package sobel_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned PixWDefault = 8;
  localparam int unsigned WinTaps     = 9;

  // Window tap indices: p0..p2 top line (oldest), p6..p8 bottom line (current).
  // Within a line, the lowest index is the leftmost (oldest) column.
  localparam int unsigned TapP0 = 0;
  localparam int unsigned TapP1 = 1;
  localparam int unsigned TapP2 = 2;
  localparam int unsigned TapP3 = 3;
  localparam int unsigned TapP4 = 4;
  localparam int unsigned TapP5 = 5;
  localparam int unsigned TapP6 = 6;
  localparam int unsigned TapP7 = 7;
  localparam int unsigned TapP8 = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two stacked line buffers in one RAM: {lb2, lb1} per column.
// Read is combinational at the write address, so a same-cycle write sees the old word.
module sobel_line_buf #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  assign rdata_o = mem_q[addr_i];

  // Column write on pixel acceptance; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-stream to 3x3 window sequencer feeding the Sobel stage.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned PIX_W = PixWDefault,
  localparam int unsigned ColW = cnt_w(IMG_W),
  localparam int unsigned RowW = cnt_w(IMG_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pix_valid,
  input  logic [PIX_W-1:0]         pix_data,
  output logic                     pix_ready,
  output logic                     win_valid,
  output logic [WinTaps*PIX_W-1:0] win,
  output logic [RowW-1:0]          win_row,
  output logic [ColW-1:0]          win_col,
  output logic                     busy,
  output logic                     frame_done
);

  state_e                            state_q, state_d;
  logic [RowW-1:0]                   row_q, row_d;
  logic [ColW-1:0]                   col_q, col_d;
  logic [WinTaps-1:0][PIX_W-1:0]     sh_q, sh_d;
  logic [WinTaps-1:0][PIX_W-1:0]     win_q, win_d;
  logic [RowW-1:0]                   win_row_q, win_row_d;
  logic [ColW-1:0]                   win_col_q, win_col_d;
  logic                              win_valid_q, win_valid_d;
  logic                              pix_ready_q, pix_ready_d;
  logic                              busy_q, busy_d;
  logic                              frame_done_q, frame_done_d;

  logic                              accept;
  logic                              last_col, last_row;
  logic [2*PIX_W-1:0]                lb_rdata, lb_wdata;
  logic [PIX_W-1:0]                  lb1_old, lb2_old;

  assign accept   = pix_valid && pix_ready_q;
  assign last_col = (col_q == ColW'(IMG_W - 1));
  assign last_row = (row_q == RowW'(IMG_H - 1));
  assign lb1_old  = lb_rdata[PIX_W-1:0];
  assign lb2_old  = lb_rdata[2*PIX_W-1:PIX_W];
  // The old lb1 word ages into lb2; the new pixel becomes lb1.
  assign lb_wdata = {lb1_old, pix_data};

  sobel_line_buf #(
    .Depth (IMG_W),
    .Width (2 * PIX_W),
    .AddrW (ColW)
  ) u_line_buf (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb_wdata),
    .rdata_o (lb_rdata)
  );

  // Next-state: FSM sequencing, raster counters, window shift and strobe.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    sh_d         = sh_q;
    win_d        = win_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        if (accept) begin
          sh_d[TapP0] = sh_q[TapP1];
          sh_d[TapP1] = sh_q[TapP2];
          sh_d[TapP2] = lb2_old;
          sh_d[TapP3] = sh_q[TapP4];
          sh_d[TapP4] = sh_q[TapP5];
          sh_d[TapP5] = lb1_old;
          sh_d[TapP6] = sh_q[TapP7];
          sh_d[TapP7] = sh_q[TapP8];
          sh_d[TapP8] = pix_data;

          // Only full interior windows are published; border windows never strobe.
          if (row_q >= RowW'(2) && col_q >= ColW'(2)) begin
            win_valid_d = 1'b1;
            win_d       = sh_d;
            win_row_d   = row_q - RowW'(1);
            win_col_d   = col_q - ColW'(1);
          end

          if (last_col) begin
            col_d = '0;
            row_d = row_q + RowW'(1);
          end else begin
            col_d = col_q + ColW'(1);
          end

          if (last_col && last_row) begin
            state_d      = StDone;
            frame_done_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    pix_ready_d = (state_d == StRun);
    busy_d      = (state_d == StRun);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      sh_q         <= '0;
      win_q        <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      win_valid_q  <= 1'b0;
      pix_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      sh_q         <= sh_d;
      win_q        <= win_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      win_valid_q  <= win_valid_d;
      pix_ready_q  <= pix_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign win_valid  = win_valid_q;
  assign win        = win_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomized bench for sobel_window_ctrl against a frame-array reference model.
module tb_sobel_window_ctrl;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             pix_valid;
  logic [PW-1:0]    pix_data;
  logic             pix_ready;
  logic             win_valid;
  logic [9*PW-1:0]  win;
  logic [RW-1:0]    win_row;
  logic [CW-1:0]    win_col;
  logic             busy;
  logic             frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0]   frame [W*H];
  logic [9*PW-1:0] last_win;
  int              last_r;
  int              last_c;

  sobel_window_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .win_valid  (win_valid),
    .win        (win),
    .win_row    (win_row),
    .win_col    (win_col),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: (r<<4)|c continuous; 1: same data, valid toggles 1,0,1,0; 2: random data and gaps.
  task automatic run_frame(input int mode, input bit stray_start, input int abort_after);
    int n, cycles, strobes, r, c;
    bit v, exp_v, was_abort;
    logic [9*PW-1:0] exp_w;
    for (int i = 0; i < W * H; i++) begin
      frame[i] = (mode == 2) ? PW'($urandom) : PW'(((i / W) << 4) | (i % W));
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("ready_after_start", pix_ready, 1);
    check_eq("busy_after_start", busy, 1);
    n = 0; cycles = 0; strobes = 0; was_abort = 0;
    while (n < W * H) begin
      if (cycles > 20 * W * H) begin
        n_checks++; n_fail++;
        $display("FAIL cycle_budget: got %0d accepted required %0d", n, W * H);
        break;
      end
      cycles++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2) == 1;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      start     = stray_start && (n == 3);
      pix_valid = v;
      pix_data  = frame[n];
      check_eq("pix_ready_run", pix_ready, 1);
      check_eq("busy_run", busy, 1);
      @(posedge clk); #1;
      start = 1'b0;
      r = n / W;
      c = n % W;
      exp_v = v && (r >= 2) && (c >= 2);
      if (v) n++;
      check_eq("win_valid", win_valid, exp_v);
      if (exp_v) begin
        for (int k = 0; k < 9; k++) begin
          exp_w[k*PW +: PW] = frame[(r - 2 + k / 3) * W + (c - 2 + k % 3)];
        end
        check_eq("win", win, exp_w);
        check_eq("win_row", win_row, r - 1);
        check_eq("win_col", win_col, c - 1);
        last_win = exp_w; last_r = r - 1; last_c = c - 1;
        strobes++;
      end else begin
        check_eq("win_hold", win, last_win);
        check_eq("win_row_hold", win_row, last_r);
        check_eq("win_col_hold", win_col, last_c);
      end
      check_eq("frame_done", frame_done, v && (n == W * H));
      if (abort_after > 0 && n == abort_after) begin
        pix_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_pix_ready", pix_ready, 0);
        check_eq("rst_win_valid", win_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_win", win, 0);
        last_win = '0; last_r = 0; last_c = 0;
        was_abort = 1;
        break;
      end
    end
    pix_valid = 1'b0;
    if (!was_abort) begin
      @(posedge clk); #1;
      check_eq("done_pulse_end", frame_done, 0);
      check_eq("idle_ready", pix_ready, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_win_valid", win_valid, 0);
      check_eq("strobe_count", strobes, (W - 2) * (H - 2));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    last_win = '0; last_r = 0; last_c = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_pix_ready", pix_ready, 0);
    check_eq("reset_win_valid", win_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_frame_done", frame_done, 0);
    check_eq("reset_win", win, 0);
    check_eq("reset_win_row", win_row, 0);
    check_eq("reset_win_col", win_col, 0);

    // rst and start together: reset dominates.
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_eq("rst_start_busy", busy, 0);
    check_eq("rst_start_ready", pix_ready, 0);
    @(posedge clk); #1;
    check_eq("rst_start_idle", busy, 0);

    run_frame(0, 1'b0, 0);   // basic continuous frame
    run_frame(1, 1'b0, 0);   // bubbles, back-to-back start
    run_frame(0, 1'b1, 0);   // stray start during RUN
    run_frame(2, 1'b0, 9);   // mid-frame reset after 9 pixels
    run_frame(0, 1'b0, 0);   // clean frame after abort
    for (int f = 0; f < 8; f++) begin
      run_frame(2, f[0], 0);
    end
    run_frame(2, 1'b0, 13);
    run_frame(2, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
